// File: rtl/fp_adder_arbiter.sv
// fp_adder_arbiter: two clients share one combinational 13-bit fp adder {sign, exp[3:0], frac[7:0]}.
// Each operation takes three cycles: grant and latch operands, add, then signal done.
module fp_adder_arbiter #(
  parameter bit FAIR  = 1'b1,
  parameter int CNT_W = 32'd16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [12:0]      a0,
  input  logic [12:0]      b0,
  input  logic             req1,
  input  logic [12:0]      a1,
  input  logic [12:0]      b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [12:0]      result,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2} state_t;

  state_t           state_r, state_n;
  logic             owner_r, owner_n;
  logic             last_r, last_n;
  logic             win1_s;
  logic [12:0]      op_a_r, op_a_n;
  logic [12:0]      op_b_r, op_b_n;
  logic [12:0]      result_r, result_n;
  logic [12:0]      sum_s;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic             gnt0_r, gnt0_n, gnt1_r, gnt1_n;
  logic             done0_r, done0_n, done1_r, done1_n;
  logic             busy_r, busy_n;

  // Align the smaller magnitude to the larger, add or subtract, then renormalise (truncating).
  function automatic logic [12:0] fp_add(input logic [12:0] x, input logic [12:0] y);
    logic [12:0] big, sml;
    logic [3:0]  diff, e, lz;
    logic [7:0]  aligned, mag;
    logic [8:0]  sum;
    if (x[11:0] >= y[11:0]) begin
      big = x;
      sml = y;
    end else begin
      big = y;
      sml = x;
    end
    diff    = big[11:8] - sml[11:8];
    aligned = sml[7:0] >> diff;
    e       = big[11:8];
    lz      = 4'd0;
    if (big[12] == sml[12]) begin
      sum = {1'b0, big[7:0]} + {1'b0, aligned};
      if (sum[8]) begin
        mag = sum[8:1];
        e   = e + 4'd1;
      end else begin
        mag = sum[7:0];
      end
    end else begin
      mag = big[7:0] - aligned;
      casez (mag)
        8'b1???????: lz = 4'd0;
        8'b01??????: lz = 4'd1;
        8'b001?????: lz = 4'd2;
        8'b0001????: lz = 4'd3;
        8'b00001???: lz = 4'd4;
        8'b000001??: lz = 4'd5;
        8'b0000001?: lz = 4'd6;
        8'b00000001: lz = 4'd7;
        default:     lz = 4'd0;
      endcase
      mag = mag << lz;
      e   = e - lz;
    end
    if (mag == 8'd0) begin
      return 13'd0;
    end else begin
      return {big[12], e, mag};
    end
  endfunction

  // The adder only ever sees the latched operands.
  assign sum_s = fp_add(op_a_r, op_b_r);

  // Arbitration: a tie goes to the client that was not served last when FAIR is set.
  always_comb begin
    if (req0 && req1) begin
      win1_s = FAIR ? ~last_r : 1'b0;
    end else begin
      win1_s = req1;
    end
  end

  // Next-state logic plus next values of all registered outputs.
  always_comb begin
    state_n  = state_r;
    owner_n  = owner_r;
    last_n   = last_r;
    op_a_n   = op_a_r;
    op_b_n   = op_b_r;
    result_n = result_r;
    cnt_n    = cnt_r;
    case (state_r)
      IDLE: begin
        if (req0 || req1) begin
          state_n = ADD;
          owner_n = win1_s;
          last_n  = win1_s;
          op_a_n  = win1_s ? a1 : a0;
          op_b_n  = win1_s ? b1 : b0;
        end else begin
          state_n = IDLE;
        end
      end
      ADD: begin
        state_n  = DONE;
        result_n = sum_s;
        if (cnt_r != {CNT_W{1'b1}}) begin
          cnt_n = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_n = cnt_r;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    gnt0_n  = (state_n == ADD) && !owner_n;
    gnt1_n  = (state_n == ADD) && owner_n;
    done0_n = (state_n == DONE) && !owner_n;
    done1_n = (state_n == DONE) && owner_n;
    busy_n  = (state_n != IDLE);
  end

  // State and output registers; reset aborts any operation in flight without a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      owner_r  <= 1'b0;
      last_r   <= 1'b1;
      op_a_r   <= 13'd0;
      op_b_r   <= 13'd0;
      result_r <= 13'd0;
      cnt_r    <= {CNT_W{1'b0}};
      gnt0_r   <= 1'b0;
      gnt1_r   <= 1'b0;
      done0_r  <= 1'b0;
      done1_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      owner_r  <= owner_n;
      last_r   <= last_n;
      op_a_r   <= op_a_n;
      op_b_r   <= op_b_n;
      result_r <= result_n;
      cnt_r    <= cnt_n;
      gnt0_r   <= gnt0_n;
      gnt1_r   <= gnt1_n;
      done0_r  <= done0_n;
      done1_r  <= done1_n;
      busy_r   <= busy_n;
    end
  end

  assign gnt0     = gnt0_r;
  assign gnt1     = gnt1_r;
  assign done0    = done0_r;
  assign done1    = done1_r;
  assign result   = result_r;
  assign busy     = busy_r;
  assign op_count = cnt_r;

endmodule
